// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, PC limit, FSM encoding and target helper for fetch_unit
package fetch_unit_pkg;

    localparam int INSTR_W = 20;
    localparam int ADDR_W  = 10;
    localparam logic [ADDR_W-1:0] PC_MAX = 10'd1023;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Relative targets are two's-complement offsets; a plain ADDR_W-bit add
    // gives sign extension plus the modulo-1024 wrap for free.
    function automatic logic [ADDR_W-1:0] resolve_target(
        input logic              rel,
        input logic [ADDR_W-1:0] tgt,
        input logic [ADDR_W-1:0] base
    );
        return rel ? (base + tgt) : tgt;
    endfunction

endpackage

// File: rtl/fetch_unit_program_counter.sv
// rtl/fetch_unit_program_counter.sv - pc register, increment/redirect adder, pending redirect, overflow flag
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load_i            apply redirect now (fetch FSM idle)
//   hold_i            redirect seen while a fetch is outstanding
//   advance_i         fetch completed: apply redirect/pending redirect or increment
//   drop_i            discard any pending redirect (fetch abandoned)
//   redirect_rel_i    live redirect is PC-relative
//   target_i          live redirect target / offset
//   pc_o              current program counter
//   pc_next_o         value pc takes at the coming edge
//   pc_overflow_o     sticky wrap flag
module program_counter
    import fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              hold_i,
    input  logic              advance_i,
    input  logic              drop_i,
    input  logic              redirect_rel_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_next_o,
    output logic              pc_overflow_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ovf_q, ovf_d;
    logic              pend_q, pend_d;
    logic              pend_rel_q, pend_rel_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

    always_comb begin
        pc_d       = pc_q;
        ovf_d      = ovf_q;
        pend_d     = pend_q;
        pend_rel_d = pend_rel_q;
        pend_tgt_d = pend_tgt_q;
        if (load_i) begin
            pc_d = resolve_target(redirect_rel_i, target_i, pc_q);
        end else if (advance_i) begin
            // A redirect arriving on the completion cycle itself is the newest
            // one and beats anything remembered earlier in the wait.
            if (hold_i) begin
                pc_d = resolve_target(redirect_rel_i, target_i, pc_q);
            end else if (pend_q) begin
                pc_d = resolve_target(pend_rel_q, pend_tgt_q, pc_q);
            end else begin
                pc_d = pc_q + ADDR_W'(1);
                if (pc_q == PC_MAX) begin
                    ovf_d = 1'b1;
                end
            end
            pend_d = 1'b0;
        end else if (hold_i) begin
            pend_d     = 1'b1;
            pend_rel_d = redirect_rel_i;
            pend_tgt_d = target_i;
        end
        if (drop_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            ovf_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_rel_q <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            ovf_q      <= ovf_d;
            pend_q     <= pend_d;
            pend_rel_q <= pend_rel_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc_o          = pc_q;
    assign pc_next_o     = pc_d;
    assign pc_overflow_o = ovf_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with registered memory handshake
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   fetch, halted             control-unit fetch request, terminator halt
//   redirect, redirect_rel    PC write request, relative/absolute select
//   target                    absolute address or signed offset
//   imem_ack, imem_data       memory data-ready strobe and read data
//   imem_req, imem_addr       registered memory read request/address
//   instruction, instr_valid  last fetched word and its one-cycle update pulse
//   pc, pc_overflow           program counter and sticky wrap flag
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch,
    input  logic               halted,
    input  logic               redirect,
    input  logic               redirect_rel,
    input  logic [ADDR_W-1:0]  target,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               pc_overflow
);

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               halt_pend_q, halt_pend_d;

    logic               pc_load, pc_hold, pc_advance, pc_drop;
    logic [ADDR_W-1:0]  pc_next;
    logic               discard;

    program_counter u_pc (
        .clk            (clk),
        .rst            (rst),
        .load_i         (pc_load),
        .hold_i         (pc_hold),
        .advance_i      (pc_advance),
        .drop_i         (pc_drop),
        .redirect_rel_i (redirect_rel),
        .target_i       (target),
        .pc_o           (pc),
        .pc_next_o      (pc_next),
        .pc_overflow_o  (pc_overflow)
    );

    // Halt may be a short pulse during the wait, so it is remembered until ack.
    assign discard = halt_pend_q | halted;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        valid_d     = 1'b0;
        halt_pend_d = halt_pend_q;
        pc_load     = 1'b0;
        pc_hold     = 1'b0;
        pc_advance  = 1'b0;
        pc_drop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                pc_load = redirect;
                if (halted) begin
                    state_d = ST_HALT;
                end else if (fetch && !pc_overflow) begin
                    // pc_next already includes a same-cycle redirect.
                    req_d       = 1'b1;
                    addr_d      = pc_next;
                    halt_pend_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                pc_hold = redirect;
                if (halted) begin
                    halt_pend_d = 1'b1;
                end
                if (imem_ack) begin
                    req_d = 1'b0;
                    if (discard) begin
                        pc_drop = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        instr_d    = imem_data;
                        valid_d    = 1'b1;
                        pc_advance = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            addr_q      <= '0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; there are no other clocks or asynchronous inputs.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 fetch  in  1  control-unit request for the next instruction.
REQ-005 halted  in  1  terminator halt indication.
REQ-006 redirect  in  1  control-unit PC write (jump or branch taken).
REQ-007 redirect_rel  in  1  1 = PC-relative target, 0 = absolute target.
REQ-008 target  in  10  absolute address, or signed two's-complement offset.
REQ-009 imem_ack  in  1  instruction memory data-ready strobe.
REQ-010 imem_data  in  20  instruction memory read data.
REQ-011 imem_req  out  1  memory read request, registered.
REQ-012 imem_addr  out  10  memory read address, registered.
REQ-013 instruction  out  20  last fetched instruction, held until the next fetch.
REQ-014 instr_valid  out  1  one-cycle pulse when instruction updates.
REQ-015 pc  out  10  current program counter.
REQ-016 pc_overflow  out  1  sticky flag: the PC wrapped past 1023.

Function
REQ-017 SHALL implement the FSM states IDLE, WAIT and HALT.
REQ-018 IDLE: fetch=1, halted=0 and pc_overflow=0 -> next edge sets imem_req=1, sets imem_addr=pc, and enters WAIT.
REQ-019 WAIT: imem_req and imem_addr SHALL stay stable until imem_ack=1; fetch is ignored while in WAIT.
REQ-020 WAIT with imem_ack=1 -> next edge: instruction<=imem_data, instr_valid=1 for one cycle, imem_req=0, pc<=pc+1, then IDLE.
REQ-021 Minimum fetch latency is 2 edges: fetch sampled at edge n, ack in the cycle after edge n+1, instr_valid high after edge n+2.
REQ-022 PC increment wraps modulo 1024; when pc=1023 increments to 0, pc_overflow SHALL set and stay set until rst.
REQ-023 While pc_overflow=1, fetch requests SHALL be ignored; the block stays in IDLE.
REQ-024 redirect in IDLE: pc<=target if redirect_rel=0; pc<=(pc+sign-extended target) mod 1024 if redirect_rel=1; relative wrap does not set pc_overflow.
REQ-025 redirect in WAIT SHALL be latched as pending and applied on the ack edge in place of the increment; the fetched instruction is still delivered.
REQ-026 redirect and fetch in the same IDLE cycle -> the redirect applies first, and the request uses the redirected address.
REQ-027 halted=1 in IDLE -> HALT at the next edge.
REQ-028 halted=1 in WAIT -> the block completes the bus transaction, discards the data (instr_valid stays 0, pc unchanged), then enters HALT.
REQ-029 HALT SHALL be terminal until rst, with imem_req=0 and all inputs ignored.

Reset
REQ-030 rst=1 at an edge -> state IDLE, pc=0, imem_addr=0, imem_req=0, instruction=0, instr_valid=0, pc_overflow=0, pending redirect cleared.
REQ-031 rst SHALL override every other input, including mid-WAIT; an imem_ack that arrives after reset SHALL be ignored.

Structure
REQ-032 A shared package SHALL hold INSTR_W=20, ADDR_W=10, PC_MAX=1023 and the FSM state encoding.
REQ-033 A single sub-module, program_counter, SHALL hold the pc register, the increment/redirect adder, the pending-redirect latch and the overflow flag; the FSM and memory handshake stay in fetch_unit.

Verification
REQ-034 After rst: fetch pulse, ack one cycle after req, imem_data=0x12345 -> imem_addr=0, instruction=0x12345, instr_valid pulse, pc=1, latency 2 edges.
REQ-035 Wait states: ack delayed 3 cycles with fetch held high -> imem_req/imem_addr stable for 3 cycles, exactly one instr_valid pulse.
REQ-036 Redirect: pc=5, redirect with redirect_rel=1 and target=0x3FE (-2) in IDLE -> pc=3; with redirect_rel=0 and target=0x200 -> pc=0x200.
REQ-037 Overflow: pc=1023, fetch completes -> pc=0 and pc_overflow=1; a later fetch produces no imem_req.
REQ-038 Halt: halted raised in WAIT, ack two cycles later -> no instr_valid, pc unchanged, HALT entered; subsequent fetches are ignored until rst.
REQ-039 Reset mid-WAIT: rst asserted in WAIT, then ack -> all outputs at reset values, instruction=0.
